conv_result_streamer: RTL and testbench

CONV_RESULT_STREAMER -- requirements
Module: conv_result_streamer

---
 rtl/conv_result_streamer.sv | 144 ++++++++++++++
 tb/tb_conv_result_streamer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : conv_result_streamer
//  Purpose  : Captures a flattened OUT_ROWS x OUT_COLS convolution result in
//             one cycle and streams it out word by word, in raster order, over
//             a valid/ready handshake.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   system clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    start      in   capture-and-stream request (sampled only in IDLE)
//    conv_flat  in   element (r,c) at [(r*OUT_COLS+c)*DATA_W +: DATA_W]
//    m_data     out  current result word
//    m_valid    out  m_data holds a valid word
//    m_ready    in   downstream accepts the word
//    m_last     out  current word is element (OUT_ROWS-1, OUT_COLS-1)
//    m_row      out  row index of current word
//    m_col      out  column index of current word
//    busy       out  high from capture until the final handshake
//    done       out  one-cycle pulse after the final handshake
//  Build option
//    STREAMER_RELU_EN : when defined, words with the sign bit set are output
//                       as zero; handshake timing is unaffected.
// ============================================================================
module conv_result_streamer #(
    parameter  int DATA_W   = 32,
    parameter  int OUT_ROWS = 6,
    parameter  int OUT_COLS = 6,
    localparam int ROW_W    = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1,
    localparam int COL_W    = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [DATA_W*OUT_ROWS*OUT_COLS-1:0] conv_flat,
    output logic [DATA_W-1:0]                   m_data,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic                                m_last,
    output logic [ROW_W-1:0]                    m_row,
    output logic [COL_W-1:0]                    m_col,
    output logic                                busy,
    output logic                                done
);

    localparam int N_ELEM = OUT_ROWS * OUT_COLS;
    localparam int IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]        r_state;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_mem [N_ELEM];

    logic              w_stream;
    logic              w_xfer;
    logic              w_row_end;
    logic              w_col_end;
    logic              w_last;
    logic [DATA_W-1:0] w_word;

    assign w_stream  = (r_state == S_STREAM);
    assign w_xfer    = w_stream && m_ready;
    assign w_row_end = (r_row == ROW_W'(OUT_ROWS - 1));
    assign w_col_end = (r_col == COL_W'(OUT_COLS - 1));
    assign w_last    = w_row_end && w_col_end;

    // Linear index runs alongside row/col so the buffer read needs no
    // multiplier; it is cleared and advanced on exactly the same events.
    assign w_word = r_mem[r_idx];

    // Snapshot of the whole result; later changes on conv_flat are invisible
    // to the stream. Contents are only observed while streaming, so no reset.
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && start) begin
            for (int i = 0; i < N_ELEM; i++) begin
                r_mem[i] <= conv_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_STREAM;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_idx   <= '0;
                    end
                end
                S_STREAM: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                            if (w_col_end) begin
                                r_col <= '0;
                                r_row <= r_row + ROW_W'(1);
                            end else begin
                                r_col <= r_col + COL_W'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode from registered state only, so reset drives them to
    // zero immediately and they hold steady through any stall.
    assign m_valid = w_stream;
    assign busy    = w_stream;
    assign done    = (r_state == S_DONE);
    assign m_last  = w_stream && w_last;
    assign m_row   = r_row;
    assign m_col   = r_col;

`ifdef STREAMER_RELU_EN
    assign m_data = (w_stream && !w_word[DATA_W-1]) ? w_word : '0;
`else
    assign m_data = w_stream ? w_word : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_result_streamer
//  Purpose  : Self-checking bench for conv_result_streamer. A reference model
//             snapshots the input at start and predicts each word, index and
//             flag by raster position.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_result_streamer;

    localparam int DATA_W = 32;
    localparam int ROWS   = 6;
    localparam int COLS   = 6;
    localparam int N      = ROWS * COLS;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [DATA_W*N-1:0]   flat;
    logic [DATA_W-1:0]     m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;
    logic [2:0]            m_row;
    logic [2:0]            m_col;
    logic                  busy;
    logic                  done;

    int n_cmp;
    int n_err;

    conv_result_streamer #(
        .DATA_W   (DATA_W),
        .OUT_ROWS (ROWS),
        .OUT_COLS (COLS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .conv_flat (flat),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .m_row     (m_row),
        .m_col     (m_col),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference output for one captured element.
    function automatic logic [DATA_W-1:0] model_word(input logic [DATA_W-1:0] w);
`ifdef STREAMER_RELU_EN
        return w[DATA_W-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    function automatic void set_elem(input int i, input logic [DATA_W-1:0] v);
        flat[i*DATA_W +: DATA_W] = v;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N; i++) set_elem(i, DATA_W'($urandom));
    endtask

    // mode: 0 ready always high, 1 ready toggling, 2 ready random.
    // restart_at / reset_at: transfer number at which start is re-raised or
    // reset is pulsed (-1 = never). perturb: scramble conv_flat after capture.
    task automatic run_stream(input int mode, input int restart_at, input int reset_at,
                              input bit perturb);
        logic [DATA_W-1:0] cap [N];
        int k;
        int cyc;
        bit fin;
        @(negedge clk);
        check("idle_valid", 64'(m_valid), 64'd0);
        for (int i = 0; i < N; i++) cap[i] = flat[i*DATA_W +: DATA_W];
        start   = 1'b1;
        m_ready = (mode == 0);
        @(negedge clk);
        start = 1'b0;
        k = 0; cyc = 0; fin = 1'b0;
        while (!fin && cyc < 4000) begin
            if (perturb) fill_random();
            if (k == reset_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_valid", 64'(m_valid), 64'd0);
                check("rst_busy",  64'(busy),    64'd0);
                check("rst_data",  64'(m_data),  64'd0);
                check("rst_row",   64'(m_row),   64'd0);
                check("rst_col",   64'(m_col),   64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    check("post_rst_valid", 64'(m_valid), 64'd0);
                    check("post_rst_done",  64'(done),    64'd0);
                end
                m_ready = 1'b0;
                return;
            end
            check("valid", 64'(m_valid), 64'd1);
            check("busy",  64'(busy),    64'd1);
            check("done_low", 64'(done), 64'd0);
            check("data",  64'(m_data),  64'(model_word(cap[k])));
            check("row",   64'(m_row),   64'(k / COLS));
            check("col",   64'(m_col),   64'(k % COLS));
            check("last",  64'(m_last),  64'(k == N - 1));
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 2 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            start = (k == restart_at) || (perturb && k > restart_at && 1'($urandom_range(0, 1)));
            if (m_ready) begin
                if (k == N - 1) fin = 1'b1;
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b1;   // held during DONE: must be ignored there too
        if (!fin) check("timeout", 64'd0, 64'd1);
        if (mode == 0) check("no_bubbles_cycles", 64'(cyc), 64'(N));
        check("end_valid", 64'(m_valid), 64'd0);
        check("end_busy",  64'(busy),    64'd0);
        check("end_last",  64'(m_last),  64'd0);
        check("done_pulse", 64'(done),   64'd1);
        start = 1'b0;
        @(negedge clk);
        check("done_one_cycle", 64'(done),    64'd0);
        check("idle_after",     64'(m_valid), 64'd0);
        m_ready = 1'b0;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        m_ready = 1'b0;
        flat    = '0;
        repeat (2) @(negedge clk);
        check("reset_valid", 64'(m_valid), 64'd0);
        check("reset_last",  64'(m_last),  64'd0);
        check("reset_busy",  64'(busy),    64'd0);
        check("reset_done",  64'(done),    64'd0);
        check("reset_data",  64'(m_data),  64'd0);
        check("reset_row",   64'(m_row),   64'd0);
        check("reset_col",   64'(m_col),   64'd0);
        rst_n = 1'b1;

        // Constant 25.0 everywhere, ready always high.
        for (int i = 0; i < N; i++) set_elem(i, 32'h41C80000);
        run_stream(0, -1, -1, 1'b0);

        // Index pattern, ready toggling every cycle.
        for (int i = 0; i < N; i++) set_elem(i, DATA_W'(i));
        run_stream(1, -1, -1, 1'b0);

        // start re-raised at transfer 10, input scrambled after capture.
        fill_random();
        run_stream(2, 10, -1, 1'b1);

        // Reset at transfer 20, then a fresh stream from (0,0).
        fill_random();
        run_stream(2, -1, 20, 1'b0);
        fill_random();
        run_stream(0, -1, -1, 1'b0);

        // One negative element at (2,3), others 4.0.
        for (int i = 0; i < N; i++) set_elem(i, 32'h40800000);
        set_elem(2 * COLS + 3, 32'hC0800000);
        run_stream(2, -1, -1, 1'b0);

        // A few more random streams with mixed signs and random ready.
        repeat (3) begin
            fill_random();
            run_stream(2, -1, -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
